// File: rtl/booth_mult_arbiter_if.sv
// Requester-side bus of booth_mult_arbiter: per-requester request and response channels.
interface booth_mult_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 8
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ*2-1:0]     req_sign;
  logic [NUM_REQ-1:0]       resp_valid;
  logic [NUM_REQ-1:0]       resp_ready;
  logic [2*WIDTH-1:0]       resp_product;
  logic                     resp_error;

  modport master (
    output req_valid, req_a, req_b, req_sign, resp_ready,
    input  req_ready, resp_valid, resp_product, resp_error
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sign, resp_ready,
    output req_ready, resp_valid, resp_product, resp_error
  );
endinterface

// File: rtl/booth_mult_arbiter.sv
// Round-robin sharing of one sequential multiplier core between NUM_REQ requesters,
// with a watchdog that turns a missing core completion into an error response.
module booth_mult_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  booth_mult_arbiter_if.slave        bus,
  output logic                       core_start,
  output logic [WIDTH-1:0]           core_multiplicand,
  output logic [WIDTH-1:0]           core_multiplier,
  output logic [1:0]                 core_sign_mode,
  input  logic [2*WIDTH-1:0]         core_product,
  input  logic                       core_done,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int unsigned GW = $clog2(NUM_REQ);
  localparam int unsigned CW = 8;
  localparam int unsigned PW = 2 * WIDTH;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [GW-1:0]      last_q, last_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [1:0]         sign_q, sign_d;
  logic               start_q, start_d;
  logic [CW-1:0]      wdog_q, wdog_d;
  logic [PW-1:0]      prod_q, prod_d;
  logic               err_q, err_d;
  logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
  logic               busy_q, busy_d;

  logic               pick_found_c;
  logic [GW-1:0]      pick_c;
  logic [WIDTH-1:0]   sel_a_c;
  logic [WIDTH-1:0]   sel_b_c;
  logic [1:0]         sel_sign_c;
  logic [NUM_REQ-1:0] req_ready_c;
  logic               resp_take_c;

  // First valid requester after the last served one, wrapping around.
  always_comb begin : rr_search
    pick_found_c = 1'b0;
    pick_c       = last_q;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      if (!pick_found_c && bus.req_valid[GW'((32'(last_q) + k) % NUM_REQ)]) begin
        pick_found_c = 1'b1;
        pick_c       = GW'((32'(last_q) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin : operand_mux
    sel_a_c    = '0;
    sel_b_c    = '0;
    sel_sign_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_c == GW'(i)) begin
        sel_a_c    = bus.req_a[i*WIDTH +: WIDTH];
        sel_b_c    = bus.req_b[i*WIDTH +: WIDTH];
        sel_sign_c = bus.req_sign[i*2 +: 2];
      end
    end
  end

  // Accept is combinational so a request is taken in the cycle it is presented.
  always_comb begin : ready_decode
    req_ready_c = '0;
    if (!rst && state_q == S_IDLE && pick_found_c) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        req_ready_c[i] = (pick_c == GW'(i));
      end
    end
  end

  assign resp_take_c = bus.resp_ready[grant_q];

  always_comb begin : fsm_next
    state_d      = state_q;
    last_d       = last_q;
    grant_d      = grant_q;
    a_d          = a_q;
    b_d          = b_q;
    sign_d       = sign_q;
    start_d      = 1'b0;
    wdog_d       = wdog_q;
    prod_d       = prod_q;
    err_d        = err_q;
    resp_valid_d = resp_valid_q;

    unique case (state_q)
      S_IDLE: begin
        if (pick_found_c) begin
          a_d     = sel_a_c;
          b_d     = sel_b_c;
          sign_d  = sel_sign_c;
          grant_d = pick_c;
          start_d = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wdog_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wdog_d = wdog_q + CW'(1);
        // A completion on the timeout cycle still counts as a good result.
        if (core_done) begin
          prod_d       = core_product;
          err_d        = 1'b0;
          resp_valid_d = NUM_REQ'(1) << grant_q;
          state_d      = S_RESP;
        end else if (wdog_d == CW'(TIMEOUT)) begin
          prod_d       = '0;
          err_d        = 1'b1;
          resp_valid_d = NUM_REQ'(1) << grant_q;
          state_d      = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_take_c) begin
          last_d       = grant_q;
          resp_valid_d = '0;
          state_d      = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin : state_regs
    if (rst) begin
      state_q      <= S_IDLE;
      last_q       <= GW'(NUM_REQ - 1);
      grant_q      <= '0;
      a_q          <= '0;
      b_q          <= '0;
      sign_q       <= '0;
      start_q      <= 1'b0;
      wdog_q       <= '0;
      prod_q       <= '0;
      err_q        <= 1'b0;
      resp_valid_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      grant_q      <= grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sign_q       <= sign_d;
      start_q      <= start_d;
      wdog_q       <= wdog_d;
      prod_q       <= prod_d;
      err_q        <= err_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.req_ready      = req_ready_c;
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_product   = prod_q;
  assign bus.resp_error     = err_q;
  assign core_start         = start_q;
  assign core_multiplicand  = a_q;
  assign core_multiplier    = b_q;
  assign core_sign_mode     = sign_q;
  assign busy               = busy_q;
  assign grant_id           = grant_q;

endmodule
